// File: rtl/scl_stall_detector_if.sv
// Bus between the SCL stall detector and its user: control inputs and stall reports.
interface scl_stall_detector_if #(
    parameter int unsigned CNT_WIDTH = 6
);
    logic                 i_sdet_en;
    logic                 i_sdet_scl;
    logic [CNT_WIDTH-1:0] i_sdet_threshold;
    logic                 o_sdet_stall;
    logic                 o_sdet_done;
    logic [CNT_WIDTH-1:0] o_sdet_len;
    logic                 o_sdet_sat;

    modport master (
        output i_sdet_en,
        output i_sdet_scl,
        output i_sdet_threshold,
        input  o_sdet_stall,
        input  o_sdet_done,
        input  o_sdet_len,
        input  o_sdet_sat
    );

    modport slave (
        input  i_sdet_en,
        input  i_sdet_scl,
        input  i_sdet_threshold,
        output o_sdet_stall,
        output o_sdet_done,
        output o_sdet_len,
        output o_sdet_sat
    );
endinterface

// File: rtl/scl_stall_detector.sv
// Target-side SCL stall detector: declares a stall once the synchronized SCL has been low
// for a programmable number of cycles, pulses done on release and reports the low time.
module scl_stall_detector #(
    parameter int unsigned CNT_WIDTH   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 i_sdet_clk,
    input logic                 i_sdet_rst,
    scl_stall_detector_if.slave sdet
);
    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StStalled
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   scl_s;
    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   thr_nz;
    logic                   thr_hit;
    logic                   stall_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   len_q;
    logic                   sat_q;

    // SCL synchronizer; stages reset to the idle-high level so reset never looks like a fall.
    always_ff @(posedge i_sdet_clk or posedge i_sdet_rst) begin
        if (i_sdet_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sdet.i_sdet_scl};
        end
    end

    assign scl_s = sync_q[SYNC_STAGES-1];

    // Saturating next count and threshold compare (cnt_q is 0 in idle, so this covers entry).
    always_comb begin
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        thr_nz  = (sdet.i_sdet_threshold != '0);
        thr_hit = thr_nz && (cnt_inc >= sdet.i_sdet_threshold);
    end

    // Stall FSM with registered outputs; disable wins over everything and keeps len/sat.
    always_ff @(posedge i_sdet_clk or posedge i_sdet_rst) begin
        if (i_sdet_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!sdet.i_sdet_en) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                stall_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                        if (thr_nz && !scl_s) begin
                            cnt_q <= CntOne;
                            if (thr_hit) begin
                                state_q <= StStalled;
                                stall_q <= 1'b1;
                            end else begin
                                state_q <= StLow;
                            end
                        end
                    end
                    StLow: begin
                        if (scl_s) begin
                            // Ordinary low phase: drop it silently.
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (thr_hit) begin
                                state_q <= StStalled;
                                stall_q <= 1'b1;
                            end
                        end
                    end
                    StStalled: begin
                        if (scl_s) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            stall_q <= 1'b0;
                            done_q  <= 1'b1;
                            len_q   <= cnt_q;
                            sat_q   <= (cnt_q == CntMax);
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        stall_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sdet.o_sdet_stall = stall_q;
    assign sdet.o_sdet_done  = done_q;
    assign sdet.o_sdet_len   = len_q;
    assign sdet.o_sdet_sat   = sat_q;
endmodule

// File: tb/tb_scl_stall_detector.sv
// Randomized and directed bench for scl_stall_detector against a run-length reference model.
module tb_scl_stall_detector;
    localparam int unsigned CW      = 6;
    localparam int unsigned SYNC    = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scl_stall_detector_if #(.CNT_WIDTH(CW)) sdet_bus ();

    scl_stall_detector #(
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .i_sdet_clk(clk),
        .i_sdet_rst(rst),
        .sdet      (sdet_bus)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int stall_cnt = 0;
    int done_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts the unbroken run of low synchronized samples while enabled.
    typedef struct {
        int run;
        bit stall;
        bit done;
        int len;
        bit sat;
    } model_t;

    model_t         m = '{run: 0, stall: 1'b0, done: 1'b0, len: 0, sat: 1'b0};
    bit [SYNC-1:0]  m_pipe = '1;

    function automatic model_t model_step(input model_t cur, input bit s, input bit en,
                                          input int thr);
        model_t nx = cur;
        nx.done = 1'b0;
        if (!en) begin
            nx.run   = 0;
            nx.stall = 1'b0;
        end else if (s) begin
            if (cur.stall) begin
                nx.done = 1'b1;
                nx.len  = (cur.run > CNT_MAX) ? CNT_MAX : cur.run;
                nx.sat  = (cur.run >= CNT_MAX);
            end
            nx.run   = 0;
            nx.stall = 1'b0;
        end else if (cur.run != 0 || thr != 0) begin
            nx.run = cur.run + 1;
            if (thr != 0 && nx.run >= thr) nx.stall = 1'b1;
        end
        return nx;
    endfunction

    // Model advances on the same edges as the DUT; raw SCL reaches it SYNC edges late.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= '{run: 0, stall: 1'b0, done: 1'b0, len: 0, sat: 1'b0};
            m_pipe <= '1;
        end else begin
            m      <= model_step(m, m_pipe[SYNC-1], sdet_bus.i_sdet_en,
                                 int'(sdet_bus.i_sdet_threshold));
            m_pipe <= {m_pipe[SYNC-2:0], sdet_bus.i_sdet_scl};
        end
    end

    // Cycle-by-cycle comparison away from the active edge, plus event counters.
    always @(negedge clk) begin
        check("stall", sdet_bus.o_sdet_stall, m.stall);
        check("done", sdet_bus.o_sdet_done, m.done);
        check("len", sdet_bus.o_sdet_len, m.len);
        check("sat", sdet_bus.o_sdet_sat, m.sat);
        if (sdet_bus.o_sdet_stall === 1'b1) stall_cnt <= stall_cnt + 1;
        if (sdet_bus.o_sdet_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic low_pulse(input int n_low, input int n_high);
        sdet_bus.i_sdet_scl = 1'b0;
        repeat (n_low) @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b1;
        repeat (n_high) @(negedge clk);
    endtask

    initial begin
        int s0;
        int d0;
        sdet_bus.i_sdet_en        = 1'b1;
        sdet_bus.i_sdet_scl       = 1'b0;
        sdet_bus.i_sdet_threshold = 6'd5;

        // Reset with SCL held low, then release.
        repeat (3) @(negedge clk);
        check("rst_stall", sdet_bus.o_sdet_stall, 0);
        check("rst_done", sdet_bus.o_sdet_done, 0);
        check("rst_len", sdet_bus.o_sdet_len, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_early", sdet_bus.o_sdet_stall, 0);
        @(negedge clk);
        check("post_rst_stall", sdet_bus.o_sdet_stall, 1);
        repeat (3) @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_done_cnt", done_cnt, 1);
        check("post_rst_len", sdet_bus.o_sdet_len, 10);

        // Short low phase: ordinary clock, no stall.
        #1 s0 = stall_cnt; d0 = done_cnt;
        @(negedge clk);
        low_pulse(3, 6);
        #1;
        check("short_stall_cnt", stall_cnt - s0, 0);
        check("short_done_cnt", done_cnt - d0, 0);
        check("short_len", sdet_bus.o_sdet_len, 10);

        // Twelve-cycle low: stall for cycles 7..14, one done, len 12.
        #1 s0 = stall_cnt; d0 = done_cnt;
        @(negedge clk);
        low_pulse(12, 6);
        #1;
        check("l12_stall_cycles", stall_cnt - s0, 8);
        check("l12_done_cnt", done_cnt - d0, 1);
        check("l12_len", sdet_bus.o_sdet_len, 12);
        check("l12_sat", sdet_bus.o_sdet_sat, 0);

        // Long low saturates the counter.
        @(negedge clk);
        low_pulse(100, 6);
        check("l100_len", sdet_bus.o_sdet_len, CNT_MAX);
        check("l100_sat", sdet_bus.o_sdet_sat, 1);

        // Disable mid-stall: stall drops next cycle, no done, len/sat retained.
        #1 d0 = done_cnt;
        @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b0;
        repeat (10) @(negedge clk);
        check("en_pre_stall", sdet_bus.o_sdet_stall, 1);
        sdet_bus.i_sdet_en = 1'b0;
        @(negedge clk);
        check("en_drop_stall", sdet_bus.o_sdet_stall, 0);
        repeat (9) @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b1;
        repeat (6) @(negedge clk);
        sdet_bus.i_sdet_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("en_drop_done_cnt", done_cnt - d0, 0);
        check("en_drop_len", sdet_bus.o_sdet_len, CNT_MAX);
        check("en_drop_sat", sdet_bus.o_sdet_sat, 1);

        // Asynchronous reset while stalled clears outputs immediately.
        @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_pre", sdet_bus.o_sdet_stall, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stall", sdet_bus.o_sdet_stall, 0);
        check("mid_rst_done", sdet_bus.o_sdet_done, 0);
        check("mid_rst_len", sdet_bus.o_sdet_len, 0);
        check("mid_rst_sat", sdet_bus.o_sdet_sat, 0);
        @(negedge clk);
        sdet_bus.i_sdet_scl = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Threshold 0 disables detection.
        sdet_bus.i_sdet_threshold = 6'd0;
        #1 s0 = stall_cnt; d0 = done_cnt;
        @(negedge clk);
        low_pulse(30, 6);
        #1;
        check("thr0_stall_cnt", stall_cnt - s0, 0);
        check("thr0_done_cnt", done_cnt - d0, 0);

        // Randomized phases, including mid-phase threshold and enable changes.
        for (int p = 0; p < 150; p++) begin
            sdet_bus.i_sdet_threshold = 6'($urandom_range(0, 12));
            sdet_bus.i_sdet_en        = ($urandom_range(0, 9) != 0);
            sdet_bus.i_sdet_scl       = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) sdet_bus.i_sdet_threshold = 6'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) sdet_bus.i_sdet_en = ~sdet_bus.i_sdet_en;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            sdet_bus.i_sdet_scl = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scl_stall_detector.md
# scl_stall_detector

Target-side counterpart of the controller SCL staller in the I3C PHY. It watches the incoming SCL line and declares a stall once SCL is held low for a programmable number of system-clock cycles. It signals when the stall is released and reports the measured low time. Its outputs let the receive path freeze bit sampling during a controller-inserted clock stall and resume cleanly afterwards.

## Interface
- CNT_WIDTH, 6: width of the threshold and the length counter.
- SYNC_STAGES, 2: number of SCL synchronizer flops (minimum 2).
- i_sdet_clk  in  1  system clock; all logic runs on the rising edge.
- i_sdet_rst  in  1  reset, asynchronous, active-high.
- i_sdet_en  in  1  detector enable.
- i_sdet_scl  in  1  raw SCL line, asynchronous to i_sdet_clk.
- i_sdet_threshold  in  CNT_WIDTH  consecutive low cycles that constitute a stall; 0 disables detection.
- o_sdet_stall  out  1  level; high while a stall is in progress.
- o_sdet_done  out  1  one-cycle pulse when a detected stall is released.
- o_sdet_len  out  CNT_WIDTH  low time of the last completed stall, in cycles, saturating.
- o_sdet_sat  out  1  high when the last completed stall saturated the counter.

## Operation
- SCL synchronizer:
  - SYNC_STAGES flops produce scl_s.
  - All stages reset to 1, the idle SCL level, so reset never creates a false falling edge.
  - No glitch filter.
- Low-cycle counter cnt (CNT_WIDTH bits):
  - Counts consecutive rising edges at which scl_s == 0.
  - Saturates at 2^CNT_WIDTH−1; never wraps.
- FSM states: IDLE, LOW, STALLED. The FSM and all outputs reset to IDLE/0.
- IDLE:
  - cnt = 0.
  - If i_sdet_en = 1, i_sdet_threshold ≠ 0 and scl_s = 0, go to LOW and set cnt = 1.
- LOW:
  - scl_s = 0: cnt increments.
  - cnt reaches i_sdet_threshold: go to STALLED and set o_sdet_stall = 1.
  - scl_s = 1 before the threshold: this was an ordinary SCL low phase. Return to IDLE with no outputs changed.
- STALLED:
  - cnt keeps counting, saturating.
  - At the first edge with scl_s = 1:
    - o_sdet_stall ← 0 and o_sdet_done ← 1 for exactly one cycle.
    - o_sdet_len ← cnt and o_sdet_sat ← (cnt == all-ones).
    - Return to IDLE.
- Threshold 1: the stall is declared at the first low edge, i.e. IDLE → STALLED directly.
- i_sdet_en = 0 in any state:
  - Next edge goes to IDLE and clears o_sdet_stall.
  - No o_sdet_done pulse; o_sdet_len and o_sdet_sat are kept.
- i_sdet_threshold is sampled every cycle. Lowering it below the current cnt while in LOW declares the stall on the next edge (compare is cnt ≥ threshold).
- Reset mid-operation clears everything immediately, including o_sdet_len and o_sdet_sat, with no done pulse.

## Timing
- Raw SCL to scl_s latency: SYNC_STAGES cycles.
- All outputs are registered.
- Stall assertion:
  - o_sdet_stall is visible the cycle after the edge at which the threshold-th consecutive low sample is taken.
  - From the raw SCL falling edge this is threshold + SYNC_STAGES cycles, ±1 for the asynchronous phase.
- Stall release:
  - o_sdet_done rises and o_sdet_stall falls on the same edge.
  - This is SYNC_STAGES cycles (±1) after the raw SCL rising edge.
  - o_sdet_len and o_sdet_sat update on that same edge and hold until the next completed stall or reset.
- o_sdet_done never coincides with o_sdet_stall = 1.
- A new stall can start the cycle after o_sdet_done.
- Reset deassertion: first detection is possible SYNC_STAGES cycles later.

## Test plan
- Reset with SCL held low, release reset, en = 1, threshold = 5:
  - outputs 0 during reset;
  - o_sdet_stall asserts 5 + 2 cycles after reset deassertion;
  - no spurious done pulse.
- Threshold 5, SCL low for 3 cycles then high:
  - o_sdet_stall and o_sdet_done stay 0;
  - o_sdet_len unchanged.
- Threshold 5, SCL low for 12 cycles then high:
  - o_sdet_stall high from cycle 7 to 14 (relative to the raw fall);
  - a single o_sdet_done pulse;
  - o_sdet_len = 12, o_sdet_sat = 0.
- CNT_WIDTH 6, threshold 5, SCL low for 100 cycles:
  - o_sdet_len = 63, o_sdet_sat = 1.
- Threshold 5, SCL low for 20 cycles, drop en at cycle 10:
  - o_sdet_stall falls the next cycle;
  - no o_sdet_done;
  - o_sdet_len keeps its previous value.
- Mid-stall events:
  - Assert reset during STALLED: all outputs 0 immediately.
  - Threshold 0 with SCL low for 30 cycles: no stall ever declared.
